// File: rtl/mod_err_demod_v2.sv
// Square-wave modulator with windowed, averaged demodulation of the ADC stream.
// Produces a signed, offset-corrected, saturated error word per half or per period.
module mod_err_demod_v2 #(
    parameter int ADC_BIT = 14,
    parameter int OUT_W   = 32,
    parameter int CNT_W   = 32,
    parameter int AVG_MAX = 10
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_en,
    input  logic                      i_mode,
    input  logic [CNT_W-1:0]          i_freq_cnt,
    input  logic signed [OUT_W-1:0]   i_amp_H,
    input  logic signed [OUT_W-1:0]   i_amp_L,
    input  logic                      i_polarity,
    input  logic [CNT_W-1:0]          i_wait_cnt,
    input  logic [3:0]                i_avg_sel,
    input  logic signed [OUT_W-1:0]   i_err_offset,
    input  logic signed [ADC_BIT-1:0] i_adc_data,
    output logic signed [OUT_W-1:0]   o_mod_out,
    output logic                      o_status,
    output logic                      o_stepTrig,
    output logic signed [OUT_W-1:0]   o_err,
    output logic                      o_err_valid,
    output logic                      o_short,
    output logic                      o_sat
);
    localparam int AW = ADC_BIT + AVG_MAX + 1;
    localparam int EW = OUT_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACC  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(2);
    localparam logic [3:0]       SEL_MAX = 4'(AVG_MAX);

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        k_q, k_d;
    logic [CNT_W-1:0]        n_q, n_d;
    logic [CNT_W-1:0]        waitCnt_q, waitCnt_d;
    logic [CNT_W:0]          winEnd_q, winEnd_d;
    logic [3:0]              sel_q, sel_d;
    logic                    mode_q, mode_d;
    logic                    short_q, short_d;
    logic                    shortH_q, shortH_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic signed [AW-1:0]    avgH_q, avgH_d;
    logic                    status_q, status_d;
    logic signed [OUT_W-1:0] mod_q, mod_d;
    logic                    stepTrig_q, stepTrig_d;
    logic signed [OUT_W-1:0] err_q, err_d;
    logic                    errValid_q, errValid_d;
    logic                    errShort_q, errShort_d;
    logic                    sat_q, sat_d;

    logic [CNT_W-1:0]        nNew;
    logic [3:0]              selNew;
    logic [CNT_W:0]          winEndNew;
    logic                    shortNew;
    logic signed [AW-1:0]    adcExt;
    logic signed [AW-1:0]    accNext;
    logic signed [AW-1:0]    avg;
    logic signed [EW-1:0]    avgExt;
    logic signed [EW-1:0]    avgHExt;
    logic signed [EW-1:0]    offsetExt;
    logic signed [EW-1:0]    demod;
    logic signed [EW-1:0]    errFull;
    logic                    satFlag;
    logic signed [OUT_W-1:0] errSat;
    logic                    starting;
    logic                    halfEnd;
    logic                    toggle;
    logic                    statusNew;
    logic                    emit;

    // Window phase of a given k: settle, sampling window, or idle tail of the half.
    function automatic logic [1:0] phaseOf(input logic [CNT_W-1:0] k,
                                           input logic [CNT_W-1:0] w,
                                           input logic [CNT_W:0]   we);
        if (k < w)
            return ST_WAIT;
        else if ({1'b0, k} < we)
            return ST_ACC;
        else
            return ST_HOLD;
    endfunction

    always_comb begin
        nNew      = (i_freq_cnt < CNT_MIN) ? CNT_MIN : i_freq_cnt;
        selNew    = (i_avg_sel > SEL_MAX) ? SEL_MAX : i_avg_sel;
        winEndNew = {1'b0, i_wait_cnt} + ((CNT_W+1)'(1) << selNew);
        shortNew  = winEndNew > {1'b0, nNew};

        adcExt    = {{(AW-ADC_BIT){i_adc_data[ADC_BIT-1]}}, i_adc_data};
        accNext   = acc_q + ((state_q == ST_ACC) ? adcExt : '0);
        avg       = accNext >>> sel_q;
        avgExt    = {{(EW-AW){avg[AW-1]}}, avg};
        avgHExt   = {{(EW-AW){avgH_q[AW-1]}}, avgH_q};
        offsetExt = {i_err_offset[OUT_W-1], i_err_offset};

        demod     = mode_q ? (avgHExt - avgExt) : (status_q ? avgExt : -avgExt);
        errFull   = (i_polarity ? -demod : demod) + offsetExt;
        // Two top bits disagreeing means the sum left the OUT_W signed range.
        satFlag   = errFull[EW-1] != errFull[EW-2];
        errSat    = satFlag ? (errFull[EW-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                             : {1'b0, {(OUT_W-1){1'b1}}})
                            : errFull[OUT_W-1:0];

        starting  = (state_q == ST_IDLE);
        halfEnd   = !starting && (k_q == n_q - CNT_ONE);
        toggle    = starting || halfEnd;
        statusNew = starting ? 1'b1 : ~status_q;
        emit      = !mode_q || !status_q;
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        n_d        = n_q;
        waitCnt_d  = waitCnt_q;
        winEnd_d   = winEnd_q;
        sel_d      = sel_q;
        mode_d     = mode_q;
        short_d    = short_q;
        shortH_d   = shortH_q;
        acc_d      = acc_q;
        avgH_d     = avgH_q;
        status_d   = status_q;
        mod_d      = mod_q;
        err_d      = err_q;
        stepTrig_d = 1'b0;
        errValid_d = 1'b0;
        errShort_d = 1'b0;
        sat_d      = 1'b0;

        if (!i_en) begin
            state_d  = ST_IDLE;
            k_d      = '0;
            acc_d    = '0;
            status_d = 1'b0;
            mod_d    = '0;
        end else if (toggle) begin
            // Half boundary: latch the next half's settings and close the current window.
            status_d   = statusNew;
            mod_d      = statusNew ? i_amp_H : i_amp_L;
            stepTrig_d = statusNew;
            n_d        = nNew;
            waitCnt_d  = i_wait_cnt;
            winEnd_d   = winEndNew;
            sel_d      = selNew;
            mode_d     = i_mode;
            short_d    = shortNew;
            k_d        = '0;
            acc_d      = '0;
            state_d    = phaseOf('0, i_wait_cnt, winEndNew);
            if (halfEnd) begin
                if (mode_q && status_q) begin
                    avgH_d   = avg;
                    shortH_d = short_q;
                end
                if (emit) begin
                    err_d      = errSat;
                    errValid_d = 1'b1;
                    errShort_d = short_q | (mode_q & shortH_q);
                    sat_d      = satFlag;
                end
            end
        end else begin
            k_d     = k_q + CNT_ONE;
            acc_d   = accNext;
            state_d = phaseOf(k_q + CNT_ONE, waitCnt_q, winEnd_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            n_q        <= '0;
            waitCnt_q  <= '0;
            winEnd_q   <= '0;
            sel_q      <= '0;
            mode_q     <= 1'b0;
            short_q    <= 1'b0;
            shortH_q   <= 1'b0;
            acc_q      <= '0;
            avgH_q     <= '0;
            status_q   <= 1'b0;
            mod_q      <= '0;
            stepTrig_q <= 1'b0;
            err_q      <= '0;
            errValid_q <= 1'b0;
            errShort_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            n_q        <= n_d;
            waitCnt_q  <= waitCnt_d;
            winEnd_q   <= winEnd_d;
            sel_q      <= sel_d;
            mode_q     <= mode_d;
            short_q    <= short_d;
            shortH_q   <= shortH_d;
            acc_q      <= acc_d;
            avgH_q     <= avgH_d;
            status_q   <= status_d;
            mod_q      <= mod_d;
            stepTrig_q <= stepTrig_d;
            err_q      <= err_d;
            errValid_q <= errValid_d;
            errShort_q <= errShort_d;
            sat_q      <= sat_d;
        end
    end

    assign o_mod_out   = mod_q;
    assign o_status    = status_q;
    assign o_stepTrig  = stepTrig_q;
    assign o_err       = err_q;
    assign o_err_valid = errValid_q;
    assign o_short     = errShort_q;
    assign o_sat       = sat_q;

endmodule

// File: tb/tb_mod_err_demod_v2.sv
// Directed bench for mod_err_demod_v2: a vector table of full-period scenarios
// plus hand sequences for mid-run frequency change, reset and enable handling.
module tb_mod_err_demod_v2;
    logic               i_clk = 1'b0;
    logic               i_rst_n;
    logic               i_en;
    logic               i_mode;
    logic [31:0]        i_freq_cnt;
    logic signed [31:0] i_amp_H;
    logic signed [31:0] i_amp_L;
    logic               i_polarity;
    logic [31:0]        i_wait_cnt;
    logic [3:0]         i_avg_sel;
    logic signed [31:0] i_err_offset;
    logic signed [13:0] i_adc_data;
    logic signed [31:0] o_mod_out;
    logic               o_status;
    logic               o_stepTrig;
    logic signed [31:0] o_err;
    logic               o_err_valid;
    logic               o_short;
    logic               o_sat;

    mod_err_demod_v2 dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_en         (i_en),
        .i_mode       (i_mode),
        .i_freq_cnt   (i_freq_cnt),
        .i_amp_H      (i_amp_H),
        .i_amp_L      (i_amp_L),
        .i_polarity   (i_polarity),
        .i_wait_cnt   (i_wait_cnt),
        .i_avg_sel    (i_avg_sel),
        .i_err_offset (i_err_offset),
        .i_adc_data   (i_adc_data),
        .o_mod_out    (o_mod_out),
        .o_status     (o_status),
        .o_stepTrig   (o_stepTrig),
        .o_err        (o_err),
        .o_err_valid  (o_err_valid),
        .o_short      (o_short),
        .o_sat        (o_sat)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        mode;
        logic [31:0] freq;
        logic [31:0] waitc;
        logic [3:0]  sel;
        logic [31:0] ampH;
        logic [31:0] ampL;
        logic        pol;
        logic [31:0] off;
        logic [13:0] adcH;
        logic [13:0] adcL;
        logic [31:0] err0;
        logic [31:0] err1;
        logic        short0;
        logic        short1;
        logic        sat0;
        logic        sat1;
        int          gap;
    } vec_t;

    localparam int NVEC = 10;
    vec_t        vecs[NVEC];
    int          checks = 0;
    int          errors = 0;
    logic [13:0] curAdcH;
    logic [13:0] curAdcL;

    function automatic vec_t mk(input logic [31:0] mode, freq, waitc, sel, ampH, ampL,
                                input logic [31:0] pol, off, adcH, adcL, err0, err1,
                                input logic [31:0] short0, short1, sat0, sat1,
                                input int gap);
        vec_t v;
        v.mode   = mode[0];
        v.freq   = freq;
        v.waitc  = waitc;
        v.sel    = sel[3:0];
        v.ampH   = ampH;
        v.ampL   = ampL;
        v.pol    = pol[0];
        v.off    = off;
        v.adcH   = adcH[13:0];
        v.adcL   = adcL[13:0];
        v.err0   = err0;
        v.err1   = err1;
        v.short0 = short0[0];
        v.short1 = short1[0];
        v.sat0   = sat0[0];
        v.sat1   = sat1[0];
        v.gap    = gap;
        return v;
    endfunction

    // The ADC follows the modulation: H-level sample while o_status is high.
    task automatic tick();
        @(posedge i_clk);
        #1;
        i_adc_data = o_status ? curAdcH : curAdcL;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h (%0d) required=0x%08h (%0d)",
                     name, act, $signed(act), exp, $signed(exp));
        end
    endtask

    task automatic waitValid(input int maxCycles, output int cycles, output logic ok);
        cycles = 0;
        ok     = 1'b0;
        while (!ok && cycles < maxCycles) begin
            tick();
            cycles++;
            ok = (o_err_valid === 1'b1);
        end
    endtask

    task automatic resetDut();
        i_rst_n = 1'b0;
        i_en    = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
    endtask

    task automatic configure(input vec_t v);
        i_mode       = v.mode;
        i_freq_cnt   = v.freq;
        i_wait_cnt   = v.waitc;
        i_avg_sel    = v.sel;
        i_amp_H      = v.ampH;
        i_amp_L      = v.ampL;
        i_polarity   = v.pol;
        i_err_offset = v.off;
        curAdcH      = v.adcH;
        curAdcL      = v.adcL;
        i_adc_data   = v.adcH;
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        int   cyc;
        logic ok;
        string tag;
        tag = $sformatf("v%0d", idx);
        configure(v);
        resetDut();
        i_en = 1'b1;
        tick();
        checkOutput({tag, ".startMod"}, o_mod_out, v.ampH);
        checkOutput({tag, ".startTrig"}, o_stepTrig, 1);
        checkOutput({tag, ".startStatus"}, o_status, 1);
        waitValid(4 * v.gap + 10, cyc, ok);
        checkOutput({tag, ".gap0"}, cyc, v.gap);
        checkOutput({tag, ".err0"}, o_err, v.err0);
        checkOutput({tag, ".short0"}, o_short, v.short0);
        checkOutput({tag, ".sat0"}, o_sat, v.sat0);
        checkOutput({tag, ".status0"}, o_status, v.mode);
        checkOutput({tag, ".mod0"}, o_mod_out, v.mode ? v.ampH : v.ampL);
        waitValid(4 * v.gap + 10, cyc, ok);
        checkOutput({tag, ".gap1"}, cyc, v.gap);
        checkOutput({tag, ".err1"}, o_err, v.err1);
        checkOutput({tag, ".short1"}, o_short, v.short1);
        checkOutput({tag, ".sat1"}, o_sat, v.sat1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        int   cyc;
        int   pulses;
        logic ok;

        vecs[0] = mk(0, 50, 10, 4, 1000, -1000, 0, 50, 100, 100, 150, -50, 0, 0, 0, 0, 50);
        vecs[1] = mk(1, 50, 10, 4, 1000, -1000, 0, 50, 100, 60, 90, 90, 0, 0, 0, 0, 100);
        vecs[2] = mk(1, 50, 10, 4, 1000, -1000, 1, 50, 100, 60, 10, 10, 0, 0, 0, 0, 100);
        vecs[3] = mk(0, 20, 10, 4, 1000, -1000, 0, 50, 100, 100, 112, -12, 1, 1, 0, 0, 20);
        vecs[4] = mk(0, 20, 25, 4, 1000, -1000, 0, 50, 100, 100, 50, 50, 1, 1, 0, 0, 20);
        vecs[5] = mk(0, 50, 10, 4, 1000, -1000, 0, 32'h7FFFFFF0, 100, 100,
                     32'h7FFFFFFF, 32'h7FFFFF8C, 0, 0, 1, 0, 50);
        vecs[6] = mk(0, 50, 10, 4, 1000, -1000, 0, 32'h80000005, 100, 100,
                     32'h80000069, 32'h80000000, 0, 0, 0, 1, 50);
        vecs[7] = mk(0, 1100, 0, 12, 1000, -1000, 0, 50, 100, 100, 150, -50, 0, 0, 0, 0, 1100);
        vecs[8] = mk(0, 5, 2, 2, 3, -7, 0, 0, -5, -5, -4, 4, 1, 1, 0, 0, 5);
        vecs[9] = mk(0, 0, 0, 0, 1000, -1000, 0, 0, 7, 7, 7, -7, 0, 0, 0, 0, 2);

        configure(vecs[0]);
        resetDut();
        checkOutput("rst.mod", o_mod_out, 0);
        checkOutput("rst.status", o_status, 0);
        checkOutput("rst.trig", o_stepTrig, 0);
        checkOutput("rst.err", o_err, 0);
        checkOutput("rst.valid", o_err_valid, 0);
        checkOutput("rst.short", o_short, 0);
        checkOutput("rst.sat", o_sat, 0);

        for (int i = 0; i < NVEC; i++)
            applyStimulus(i, vecs[i]);

        // Frequency change at k=20: current half keeps 50, next half uses 30.
        configure(vecs[0]);
        resetDut();
        i_en = 1'b1;
        tick();
        repeat (20) tick();
        i_freq_cnt = 30;
        waitValid(200, cyc, ok);
        checkOutput("freq.firstHalf", cyc, 30);
        checkOutput("freq.err0", o_err, 150);
        waitValid(200, cyc, ok);
        checkOutput("freq.secondHalf", cyc, 30);
        checkOutput("freq.err1", o_err, -50);
        checkOutput("freq.trig", o_stepTrig, 1);

        // Reset asserted at k=15 of the L-half sampling window.
        configure(vecs[0]);
        resetDut();
        i_en = 1'b1;
        tick();
        waitValid(200, cyc, ok);
        checkOutput("rstRun.err", o_err, 150);
        repeat (15) tick();
        i_rst_n = 1'b0;
        tick();
        checkOutput("rstRun.err0", o_err, 0);
        checkOutput("rstRun.valid", o_err_valid, 0);
        checkOutput("rstRun.mod", o_mod_out, 0);
        checkOutput("rstRun.status", o_status, 0);
        pulses = 0;
        for (int j = 0; j < 3; j++) begin
            tick();
            pulses += (o_err_valid | o_stepTrig | o_status) ? 1 : 0;
        end
        checkOutput("rstRun.resetWins", pulses, 0);
        i_rst_n = 1'b1;
        tick();
        checkOutput("rstRun.restartTrig", o_stepTrig, 1);
        checkOutput("rstRun.restartStatus", o_status, 1);
        waitValid(200, cyc, ok);
        checkOutput("rstRun.gap", cyc, 50);
        checkOutput("rstRun.errAfter", o_err, 150);

        // Enable dropped mid L half: idle with o_err held, then restart on H.
        repeat (5) tick();
        i_en = 1'b0;
        tick();
        checkOutput("en.status", o_status, 0);
        checkOutput("en.mod", o_mod_out, 0);
        checkOutput("en.errHeld", o_err, 150);
        curAdcH = -2000;
        curAdcL = -2000;
        pulses  = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            pulses += (o_err_valid | o_stepTrig) ? 1 : 0;
        end
        checkOutput("en.idlePulses", pulses, 0);
        checkOutput("en.errStill", o_err, 150);
        curAdcH = 100;
        curAdcL = 100;
        i_en = 1'b1;
        tick();
        checkOutput("en.reTrig", o_stepTrig, 1);
        checkOutput("en.reStatus", o_status, 1);
        checkOutput("en.reMod", o_mod_out, 1000);
        waitValid(200, cyc, ok);
        checkOutput("en.reGap", cyc, 50);
        checkOutput("en.reErr", o_err, 150);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
